fbwriter_mc: RTL and testbench

FBWRITER_MC -- requirements
Module: fbwriter_mc

---
 rtl/fbwriter_mc_if.sv | 33 +++
 rtl/fbwriter_mc.sv | 150 +++++++++++++++
 tb/tb_fbwriter_mc.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fbwriter_mc_if.sv
// PLB master-side bus signals between the frame-buffer writer and the bus.
interface fbwriter_mc_if #(
  parameter int C_MST_AWIDTH = 32,
  parameter int C_MST_DWIDTH = 32
);
  logic                      IP2Bus_MstWr_Req;
  logic                      IP2Bus_MstRd_Req;
  logic                      IP2Bus_Mst_Lock;
  logic                      IP2Bus_Mst_Reset;
  logic [C_MST_AWIDTH-1:0]   IP2Bus_Mst_Addr;
  logic [C_MST_DWIDTH/8-1:0] IP2Bus_Mst_BE;
  logic [C_MST_DWIDTH-1:0]   IP2Bus_MstWr_d;
  logic                      Bus2IP_Mst_CmdAck;
  logic                      Bus2IP_Mst_Cmplt;
  logic                      Bus2IP_Mst_Error;
  logic                      Bus2IP_Mst_Rearbitrate;
  logic                      Bus2IP_Mst_Cmd_Timeout;
  logic                      Bus2IP_MstWr_dst_rdy_n;

  modport master (
    output IP2Bus_MstWr_Req, IP2Bus_MstRd_Req, IP2Bus_Mst_Lock, IP2Bus_Mst_Reset,
           IP2Bus_Mst_Addr, IP2Bus_Mst_BE, IP2Bus_MstWr_d,
    input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
           Bus2IP_Mst_Rearbitrate, Bus2IP_Mst_Cmd_Timeout, Bus2IP_MstWr_dst_rdy_n
  );

  modport slave (
    input  IP2Bus_MstWr_Req, IP2Bus_MstRd_Req, IP2Bus_Mst_Lock, IP2Bus_Mst_Reset,
           IP2Bus_Mst_Addr, IP2Bus_Mst_BE, IP2Bus_MstWr_d,
    output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
           Bus2IP_Mst_Rearbitrate, Bus2IP_Mst_Cmd_Timeout, Bus2IP_MstWr_dst_rdy_n
  );
endinterface

// File: rtl/fbwriter_mc.sv
// Frame-buffer writer: round-robin drains rasterizer FIFOs and issues one
// single-beat PLB write per pixel, with bounded retry on error/timeout.
// Bit labels on the FIFO word and the bus address are big-endian (bit 0 = MSB);
// vectors are declared descending, so label i of a W-bit field sits at [W-1-i].
module fbwriter_mc #(
  parameter logic [10:0] FB_BASE_ADDR      = 11'b1001_0000_000,
  parameter int          NUM_CH            = 4,
  parameter int          LINE_LEN          = 9,
  parameter int          COL_LEN           = 10,
  parameter int          RAST_FBW_FIFO_LEN = 96,
  parameter int          MAX_RETRY         = 3,
  parameter int          C_MST_AWIDTH      = 32,
  parameter int          C_MST_DWIDTH      = 32
)(
  input  logic                                PLB_clk,
  input  logic                                reset_n,
  input  logic                                enable,
  input  logic [NUM_CH*RAST_FBW_FIFO_LEN-1:0] fifo_data,
  input  logic [NUM_CH-1:0]                   fifo_empty,
  output logic [NUM_CH-1:0]                   fifo_rd_en,
  fbwriter_mc_if.master                       bus,
  output logic [2:0]                          state,
  output logic                                busy,
  output logic [31:0]                         pix_count,
  output logic [15:0]                         err_count
);
  localparam int W  = RAST_FBW_FIFO_LEN;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW = $clog2(NUM_CH * W);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    IDLE = 3'd0, FIFO_READ = 3'd1, LATCH = 3'd2, REQ = 3'd3, WAIT_CMPLT = 3'd4, RETRY = 3'd5
  } st_t;

  st_t               st, st_d;
  logic [CW-1:0]     grant, last_grant, pick, cand;
  logic              any_req, req_q, req_d, fail, pix_inc;
  logic [NUM_CH-1:0] rd_d;
  logic [LINE_LEN-1:0] line_q;
  logic [COL_LEN-1:0]  col_q;
  logic [31:0]       colour_q;
  logic [RW-1:0]     retries;
  logic [IW-1:0]     base;
  logic              unused_dst_rdy;

  // Data ready does not steer the single-beat write.
  assign unused_dst_rdy = bus.Bus2IP_MstWr_dst_rdy_n;

  // Channel 0 occupies the most significant word of fifo_data.
  assign base = IW'((NUM_CH - 1 - int'(grant)) * W);

  // Round-robin pick: first non-empty channel after last_grant (smallest k wins).
  always_comb begin
    any_req = 1'b0;
    pick    = last_grant;
    cand    = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = CW'((int'(last_grant) + k) % NUM_CH);
      if (!fifo_empty[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  // Next state, FIFO read strobe and bus request.
  always_comb begin
    st_d    = st;
    req_d   = 1'b0;
    rd_d    = '0;
    fail    = 1'b0;
    pix_inc = 1'b0;
    case (st)
      IDLE: if (enable && any_req) begin
        st_d       = FIFO_READ;
        rd_d[pick] = 1'b1;
      end
      FIFO_READ: st_d = LATCH;
      LATCH: begin
        st_d  = REQ;
        req_d = 1'b1;
      end
      REQ: begin
        if (req_q && bus.Bus2IP_Mst_CmdAck) st_d = WAIT_CMPLT;
        else if (bus.Bus2IP_Mst_Cmd_Timeout) fail = 1'b1;
        // A rearbitrate drops Req for one cycle; the low cycle then reasserts.
        else req_d = !(req_q && bus.Bus2IP_Mst_Rearbitrate);
      end
      WAIT_CMPLT: begin
        if ((bus.Bus2IP_Mst_Cmplt && bus.Bus2IP_Mst_Error) || bus.Bus2IP_Mst_Cmd_Timeout)
          fail = 1'b1;
        else if (bus.Bus2IP_Mst_Cmplt) begin
          st_d    = IDLE;
          pix_inc = 1'b1;
        end
      end
      RETRY: begin
        st_d  = REQ;
        req_d = 1'b1;
      end
      default: st_d = IDLE;
    endcase
    if (fail) st_d = (int'(retries) < MAX_RETRY) ? RETRY : IDLE;
  end

  // State, pixel registers and counters.
  always_ff @(posedge PLB_clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= IDLE;
      req_q      <= 1'b0;
      fifo_rd_en <= '0;
      grant      <= '0;
      last_grant <= CW'(NUM_CH - 1);
      line_q     <= '0;
      col_q      <= '0;
      colour_q   <= '0;
      retries    <= '0;
      pix_count  <= '0;
      err_count  <= '0;
    end else begin
      st         <= st_d;
      req_q      <= req_d;
      fifo_rd_en <= rd_d;
      if (st == IDLE && st_d == FIFO_READ) grant <= pick;
      if (st == LATCH) begin
        line_q     <= fifo_data[base + IW'(W - 16) +: LINE_LEN];
        col_q      <= fifo_data[base + IW'(W - 32) +: COL_LEN];
        colour_q   <= fifo_data[base + IW'(W - 64) +: 32];
        last_grant <= grant;
        retries    <= '0;
      end
      if (fail) begin
        if (int'(retries) < MAX_RETRY) retries <= retries + RW'(1);
        else if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
      if (pix_inc) pix_count <= pix_count + 32'd1;
    end
  end

  assign bus.IP2Bus_MstWr_Req = req_q;
  assign bus.IP2Bus_MstRd_Req = 1'b0;
  assign bus.IP2Bus_Mst_Lock  = 1'b0;
  assign bus.IP2Bus_Mst_Reset = 1'b0;
  assign bus.IP2Bus_Mst_BE    = '1;
  assign bus.IP2Bus_Mst_Addr  = C_MST_AWIDTH'({FB_BASE_ADDR, line_q, col_q, 2'b00});
  assign bus.IP2Bus_MstWr_d   = C_MST_DWIDTH'(colour_q);
  assign state                = st;
  assign busy                 = (st != IDLE);
endmodule

// File: tb/tb_fbwriter_mc.sv
// Randomized bench for fbwriter_mc: FIFO queues + scripted PLB responder,
// with a round-robin/retry reference model computed at the pixel level.
module tb_fbwriter_mc;
  localparam int NCH = 4, W = 96, MAXR = 3;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          nfail;
    bit          to;
    int          ack_dly;
    int          cmp_dly;
    bit          rearb;
  } pix_t;

  logic PLB_clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
  logic [NCH*W-1:0] fifo_data = '0;
  logic [NCH-1:0]   fifo_empty = '1, fifo_rd_en;
  logic [2:0]  state;
  logic        busy;
  logic [31:0] pix_count;
  logic [15:0] err_count;

  fbwriter_mc_if bus();

  fbwriter_mc #(.NUM_CH(NCH)) dut (
    .PLB_clk(PLB_clk), .reset_n(reset_n), .enable(enable),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .bus(bus), .state(state), .busy(busy), .pix_count(pix_count), .err_count(err_count)
  );

  always #5 PLB_clk = ~PLB_clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // FIFO contents, model queues and expected service order.
  logic [W-1:0] fq[NCH][$];
  logic [W-1:0] cur[NCH];
  pix_t mq[NCH][$];
  pix_t exp_q[$];
  int mlast = NCH - 1, exp_pix = 0, exp_err = 0, exp_rises = 0;

  // Responder state.
  int   cyc = 0, t_rd = 0, ph = 0, att = 0, rcnt = 0, ccnt = 0, rises = 0;
  bit   rb_done = 0, req_prev = 0;
  logic [31:0] a0 = '0, d0 = '0;
  pix_t p, pdone, dflt;

  task automatic end_att(input bit f);
    rcnt = 0;
    if (!f || att == MAXR) begin
      if (exp_q.size() > 0) begin
        chk("pix_addr", a0, exp_q[0].addr);
        chk("pix_data", d0, exp_q[0].data);
        pdone = exp_q.pop_front();
      end
      att = 0;
      rb_done = 0;
    end else att++;
  endtask

  // FIFO pop, request monitor and PLB responder, all on the falling edge.
  always @(negedge PLB_clk) begin
    cyc++;
    bus.Bus2IP_Mst_CmdAck      = 1'b0;
    bus.Bus2IP_Mst_Cmplt       = 1'b0;
    bus.Bus2IP_Mst_Error       = 1'b0;
    bus.Bus2IP_Mst_Rearbitrate = 1'b0;
    bus.Bus2IP_Mst_Cmd_Timeout = 1'b0;
    bus.Bus2IP_MstWr_dst_rdy_n = cyc[0];
    if (!reset_n) begin
      ph = 0; att = 0; rcnt = 0; rb_done = 0;
    end else begin
      if (fifo_rd_en != '0) begin
        chk("rd_state", 64'(state), 64'd1);
        chk("rd_onehot", 64'($countones(fifo_rd_en)), 64'd1);
        t_rd = cyc;
        for (int c = 0; c < NCH; c++)
          if (fifo_rd_en[c] && fq[c].size() > 0) cur[c] = fq[c].pop_front();
      end
      if (bus.IP2Bus_MstWr_Req && !req_prev) rises++;
      p = (exp_q.size() > 0) ? exp_q[0] : dflt;
      case (ph)
        0: if (bus.IP2Bus_MstWr_Req) begin
          if (rcnt == 0) begin
            if (att == 0) begin
              a0 = bus.IP2Bus_Mst_Addr;
              d0 = bus.IP2Bus_MstWr_d;
              if (exp_q.size() == 0) chk("stray_req", 1, 0);
              else chk("lat", 64'(cyc - t_rd), 64'd2);
            end else begin
              chk("retry_addr", bus.IP2Bus_Mst_Addr, a0);
              chk("retry_data", bus.IP2Bus_MstWr_d, d0);
            end
          end
          rcnt++;
          if (p.rearb && !rb_done && att == 0) begin
            bus.Bus2IP_Mst_Rearbitrate = 1'b1;
            rb_done = 1;
            ph = 2;
          end else if (rcnt >= p.ack_dly) begin
            if (att < p.nfail && p.to) begin
              bus.Bus2IP_Mst_Cmd_Timeout = 1'b1;
              end_att(1'b1);
            end else begin
              bus.Bus2IP_Mst_CmdAck = 1'b1;
              ccnt = 0;
              ph = 1;
            end
          end
        end
        1: begin
          ccnt++;
          if (ccnt >= p.cmp_dly) begin
            bus.Bus2IP_Mst_Cmplt = 1'b1;
            bus.Bus2IP_Mst_Error = (att < p.nfail);
            end_att(att < p.nfail);
            ph = 0;
          end
        end
        2: begin chk("rearb_low", 64'(bus.IP2Bus_MstWr_Req), 64'd0); ph = 3; end
        default: begin chk("rearb_high", 64'(bus.IP2Bus_MstWr_Req), 64'd1); ph = 0; end
      endcase
    end
    req_prev = bus.IP2Bus_MstWr_Req;
    for (int c = 0; c < NCH; c++) fifo_empty[c] = (fq[c].size() == 0);
    fifo_data = {cur[0], cur[1], cur[2], cur[3]};
  end

  // Word layout (bit 0 = MSB): pad 0-6, line 7-15, pad 16-21, col 22-31, colour 32-63, pad 64-95.
  task automatic add_pix(input int c, input logic [8:0] ln, input logic [9:0] cl,
                         input logic [31:0] colour, input int nfail, input bit to,
                         input int ack, input int cmp, input bit rb);
    pix_t e;
    fq[c].push_back({7'($urandom), ln, 6'($urandom), cl, colour, 32'($urandom)});
    e.addr = 32'h9000_0000 + (32'(ln) << 12) + (32'(cl) << 2);
    e.data = colour; e.nfail = nfail; e.to = to;
    e.ack_dly = ack; e.cmp_dly = cmp; e.rearb = rb;
    mq[c].push_back(e);
  endtask

  task automatic add_rand(input int c);
    int r;
    r = $urandom_range(0, 9);
    add_pix(c, 9'($urandom), 10'($urandom), $urandom, (r < 6) ? 0 : r - 5,
            1'($urandom), $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 4) == 0);
  endtask

  // Reference round robin over everything queued, plus expected counters.
  task automatic plan_order();
    bit found;
    pix_t e;
    do begin
      found = 0;
      for (int k = 1; k <= NCH && !found; k++) begin
        if (mq[(mlast + k) % NCH].size() > 0) begin
          mlast = (mlast + k) % NCH;
          e = mq[mlast].pop_front();
          exp_q.push_back(e);
          found = 1;
          if (e.nfail > MAXR) begin exp_err++; exp_rises += MAXR + 1; end
          else begin exp_pix++; exp_rises += e.nfail + 1; end
          if (e.rearb) exp_rises++;
        end
      end
    end while (found);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || state != 3'd0) && n < 3000) begin
      @(posedge PLB_clk); #1; n++;
    end
    chk({tag, "_done"}, 64'(n < 3000), 64'd1);
    repeat (3) @(posedge PLB_clk);
    #1;
    chk({tag, "_pix"}, pix_count, exp_pix);
    chk({tag, "_err"}, err_count, exp_err);
    chk({tag, "_rises"}, rises, exp_rises);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    dflt = '{addr: '0, data: '0, nfail: 0, to: 0, ack_dly: 1, cmp_dly: 1, rearb: 0};
    for (int c = 0; c < NCH; c++) cur[c] = '0;
    repeat (3) @(posedge PLB_clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", bus.IP2Bus_MstWr_Req, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_pix", pix_count, 0);
    chk("rst_err", err_count, 0);
    chk("const_ctl", {bus.IP2Bus_MstRd_Req, bus.IP2Bus_Mst_Lock, bus.IP2Bus_Mst_Reset}, 0);
    chk("const_be", bus.IP2Bus_Mst_BE, 4'hF);
    @(posedge PLB_clk); #2;
    reset_n = 1'b1;
    enable  = 1'b1;

    // Single pixel with known address.
    add_pix(0, 9'd5, 10'd7, 32'hDEADBEEF, 0, 0, 2, 2, 0);
    plan_order();
    exp_q[0].addr = 32'h9000501C;
    drain("single");

    // Round robin: two words on every channel.
    for (int i = 0; i < 2; i++) for (int c = 0; c < NCH; c++)
      add_pix(c, 9'($urandom), 10'($urandom), $urandom, 0, 0, 1, 1, 0);
    plan_order();
    drain("rr");

    // Two errored completions, then success.
    add_pix(2, 9'd100, 10'd513, 32'h0123_4567, 2, 0, 1, 2, 0);
    plan_order();
    drain("retry");

    // Timeout on every attempt: dropped, next pixel still served.
    add_pix(1, 9'h1FF, 10'h3FF, 32'hFFFF_0000, MAXR + 1, 1, 2, 1, 0);
    add_pix(3, 9'd0, 10'd0, 32'h5A5A_A5A5, 0, 0, 1, 1, 0);
    plan_order();
    drain("drop");

    // Rearbitrate in REQ.
    add_pix(0, 9'd33, 10'd44, 32'hCAFE_F00D, 0, 0, 2, 1, 1);
    plan_order();
    drain("rearb");

    // Random batches.
    for (int b = 0; b < 6; b++) begin
      for (int c = 0; c < NCH; c++) begin
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) add_rand(c);
      end
      plan_order();
      drain("rand");
    end

    // Enable low: nothing granted; mid-transaction drop affects next grant only.
    enable = 1'b0;
    add_rand(1);
    add_rand(2);
    plan_order();
    repeat (10) @(posedge PLB_clk);
    #1;
    chk("en_off_idle", state, 0);
    chk("en_off_fifo", fq[1].size() + fq[2].size(), 2);
    enable = 1'b1;
    n = 0;
    while (!bus.IP2Bus_MstWr_Req && n < 50) begin @(posedge PLB_clk); #1; n++; end
    enable = 1'b0;
    n = 0;
    while ((state != 3'd0 || exp_q.size() > 1) && n < 200) begin @(posedge PLB_clk); #1; n++; end
    repeat (10) @(posedge PLB_clk);
    #1;
    chk("en_mid_left", exp_q.size(), 1);
    chk("en_mid_idle", state, 0);
    enable = 1'b1;
    drain("en");

    // Reset while waiting for completion.
    add_pix(3, 9'd77, 10'd99, 32'h1111_2222, 0, 0, 1, 8, 0);
    plan_order();
    n = 0;
    while (state != 3'd4 && n < 50) begin @(posedge PLB_clk); #1; n++; end
    chk("rst_reach_wait", state, 4);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_req", bus.IP2Bus_MstWr_Req, 0);
    chk("arst_state", state, 0);
    chk("arst_pix", pix_count, 0);
    chk("arst_err", err_count, 0);
    chk("arst_busy", busy, 0);
    exp_q.delete();
    for (int c = 0; c < NCH; c++) fq[c].delete();
    mlast = NCH - 1; exp_pix = 0; exp_err = 0;
    @(posedge PLB_clk); #2;
    reset_n = 1'b1;
    exp_rises = rises;
    repeat (20) @(posedge PLB_clk);
    #1;
    chk("post_rst_noreq", rises, exp_rises);
    chk("post_rst_idle", state, 0);
    add_pix(2, 9'd8, 10'd9, 32'hABCD_0123, 0, 0, 1, 1, 0);
    plan_order();
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
